hex_scan_decoder: RTL and testbench
===================================

Name: hex_scan_decoder

Overview:
Receiver-side counterpart to the team's hex-to-7-segment encoder. It accepts a time-multiplexed stream of active-low 7-segment patterns, one digit per strobe, and decodes each pattern back to its 4-bit hex value. It assembles a full frame of NUM_DIGITS digits into one word, then flags completion or error. It sits on the display-bus tap so that ALU results driven onto the HEX displays can be read back and checked in hardware.

Parameters:
NUM_DIGITS, 6, digits per frame (1..8); digit i occupies value_out[4i+3:4i].
TIMEOUT, 255, maximum idle cycles allowed between accepted digits within a frame.

Ports:
clock  input  1  single system clock, rising edge.
resetn  input  1  asynchronous active-low reset.
seg_valid  input  1  seg_in and digit_sel are valid this cycle.
frame_start  input  1  qualifies the current seg_valid beat as the first digit of a frame.
digit_sel  input  3  index of the digit carried this beat.
seg_in  input  7  active-low pattern, bit6..bit0 = g,f,e,d,c,b,a.
value_out  output  4*NUM_DIGITS  last successfully decoded frame.
frame_valid  output  1  one-cycle pulse: value_out was just updated.
frame_error  output  1  one-cycle pulse: the frame was aborted.
err_code  output  2  cause of the last error: 1 bad pattern, 2 out of order, 3 timeout.
bad_digit  output  3  digit index at which the last error occurred.
busy  output  1  high while a frame is being collected.

Behaviour:
- Reset (async, resetn=0): state IDLE; value_out=0, frame_valid=0, frame_error=0, err_code=0, bad_digit=0, busy=0, digit counter=0, timeout counter=0, staging register=0.
- Decode table, seg_in to value:
  - 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7
  - 0x00->8, 0x10->9, 0x08->A, 0x03->B, 0x46->C, 0x21->D, 0x06->E, 0x0E->F
  - Any other pattern is invalid.
- State IDLE:
  - The block waits for seg_valid && frame_start && digit_sel==0.
  - Beats with seg_valid but without that combination are ignored, with no error.
  - On a start beat:
    - If the pattern is valid, store it in staging digit 0, set expected index to 1, go to COLLECT (or DONE if NUM_DIGITS==1).
    - If the pattern is invalid, go to ERR with err_code=1 and bad_digit=0.
- State COLLECT (busy=1):
  - An idle cycle with no seg_valid increments the timeout counter. When the count reaches TIMEOUT, go to ERR with err_code=3 and bad_digit = expected index.
  - seg_valid && frame_start aborts the current frame silently (no error pulse) and restarts it with this beat, which is treated as an IDLE start beat.
  - seg_valid with digit_sel != expected index: go to ERR, err_code=2, bad_digit=digit_sel.
  - seg_valid with an invalid pattern: go to ERR, err_code=1, bad_digit=digit_sel.
  - seg_valid, correct index, valid pattern:
    - Store the nibble, increment the expected index, clear the timeout counter.
    - If this was index NUM_DIGITS-1, go to DONE.
- State DONE (one cycle): copy staging to value_out, pulse frame_valid=1, return to IDLE. A start beat arriving in this cycle is accepted as an IDLE start beat.
- State ERR (one cycle):
  - Pulse frame_error=1; err_code and bad_digit hold until the next error or reset.
  - value_out keeps the previous good frame; the staging register is discarded.
  - Return to IDLE. A start beat arriving in this cycle is ignored.
- Latency: frame_valid rises exactly one cycle after the clock edge that accepts the last digit. frame_valid and frame_error are never high together.
- Reset asserted mid-frame: the partial frame is lost and value_out is cleared.

Test Plan:
1. Reset, then send digits 0..5 = 0x40,0x79,0x24,0x30,0x19,0x12 on consecutive cycles with frame_start on digit 0 -> frame_valid pulses one cycle after digit 5; value_out=0x543210; busy falls the same cycle.
2. Send a frame carrying F,E,D,C,B,A (0x0E,0x06,0x21,0x46,0x03,0x08), with 3 idle cycles between beats -> value_out=0xABCDEF, single frame_valid pulse.
3. After a good frame 0x123456, send a frame whose digit 2 = 0x7F -> frame_error pulse, err_code=1, bad_digit=2, value_out stays 0x123456.
4. Send digit 0, then digit 2 -> frame_error, err_code=2, bad_digit=2; a following correct frame decodes normally.
5. Send digit 0, then stay silent for 255 cycles -> frame_error in the timeout cycle, err_code=3, bad_digit=1; with TIMEOUT=255, 254 silent cycles produce no error.
6. Assert resetn=0 after digit 3 of a frame -> all outputs 0 immediately (async); a fresh frame 0x888888 then yields value_out=0x888888.

Source files
------------

// File: rtl/hex_scan_decoder.sv
// hex_scan_decoder: turns a strobed stream of active-low 7-segment
// patterns back into a packed hex word, one frame of digits at a time.
module hex_scan_decoder #(
    parameter int NUM_DIGITS = 6,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    seg_valid,
    input  logic                    frame_start,
    input  logic [2:0]              digit_sel,
    input  logic [6:0]              seg_in,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic                    frame_valid,
    output logic                    frame_error,
    output logic [1:0]              err_code,
    output logic [2:0]              bad_digit,
    output logic                    busy
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [2:0]    LAST = 3'(NUM_DIGITS - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] E_PAT = 2'd1;
    localparam logic [1:0] E_ORD = 2'd2;
    localparam logic [1:0] E_TMO = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE,
        S_ERR
    } state_t;

    state_t         state, state_n;
    logic [VW-1:0]  stage, stage_n;
    logic [2:0]     exp_idx, exp_n;
    logic [TW-1:0]  tmo, tmo_n;
    logic           load_val;
    logic           err_set;
    logic [1:0]     code_n;
    logic [2:0]     bad_n;
    logic           take_start;
    logic           start_beat;
    logic [4:0]     dec;

    // Bit 4 flags a legal pattern, bits 3:0 carry the nibble.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'b0;
        case (s)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    assign dec        = seg_decode(seg_in);
    assign start_beat = seg_valid && frame_start && (digit_sel == 3'd0);

    // Pulses and busy are pure state decodes, so they can never overlap.
    assign busy        = (state == S_COLLECT);
    assign frame_valid = (state == S_DONE);
    assign frame_error = (state == S_ERR);

    // Next-state, staging and error-capture logic.
    always_comb begin
        state_n    = state;
        stage_n    = stage;
        exp_n      = exp_idx;
        tmo_n      = tmo;
        load_val   = 1'b0;
        err_set    = 1'b0;
        code_n     = err_code;
        bad_n      = bad_digit;
        take_start = 1'b0;

        case (state)
            S_IDLE: begin
                take_start = start_beat;
            end
            S_DONE: begin
                state_n    = S_IDLE;
                take_start = start_beat;
            end
            S_ERR: begin
                state_n = S_IDLE;
                stage_n = '0;
                exp_n   = '0;
                tmo_n   = '0;
            end
            S_COLLECT: begin
                if (seg_valid && frame_start) begin
                    // Silent abort; a proper start beat reopens the frame.
                    state_n    = S_IDLE;
                    stage_n    = '0;
                    exp_n      = '0;
                    tmo_n      = '0;
                    take_start = start_beat;
                end else if (seg_valid) begin
                    if (digit_sel != exp_idx) begin
                        state_n = S_ERR;
                        err_set = 1'b1;
                        code_n  = E_ORD;
                        bad_n   = digit_sel;
                        stage_n = '0;
                    end else if (!dec[4]) begin
                        state_n = S_ERR;
                        err_set = 1'b1;
                        code_n  = E_PAT;
                        bad_n   = digit_sel;
                        stage_n = '0;
                    end else begin
                        stage_n[{exp_idx, 2'b00} +: 4] = dec[3:0];
                        exp_n = exp_idx + 3'd1;
                        tmo_n = '0;
                        if (exp_idx == LAST) begin
                            state_n  = S_DONE;
                            load_val = 1'b1;
                        end
                    end
                end else if (tmo == TMAX) begin
                    state_n = S_ERR;
                    err_set = 1'b1;
                    code_n  = E_TMO;
                    bad_n   = exp_idx;
                    stage_n = '0;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (take_start) begin
            tmo_n = '0;
            if (dec[4]) begin
                stage_n      = '0;
                stage_n[3:0] = dec[3:0];
                exp_n        = 3'd1;
                if (NUM_DIGITS == 1) begin
                    state_n  = S_DONE;
                    load_val = 1'b1;
                end else begin
                    state_n = S_COLLECT;
                end
            end else begin
                state_n = S_ERR;
                err_set = 1'b1;
                code_n  = E_PAT;
                bad_n   = 3'd0;
                stage_n = '0;
                exp_n   = '0;
            end
        end
    end

    // State, staging and output registers; the finished word is
    // loaded on the accepting edge so it is visible during DONE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            stage     <= '0;
            exp_idx   <= '0;
            tmo       <= '0;
            value_out <= '0;
            err_code  <= '0;
            bad_digit <= '0;
        end else begin
            state   <= state_n;
            stage   <= stage_n;
            exp_idx <= exp_n;
            tmo     <= tmo_n;
            if (load_val) begin
                value_out <= stage_n;
            end
            if (err_set) begin
                err_code  <= code_n;
                bad_digit <= bad_n;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_decoder.sv
// tb_hex_scan_decoder: table-driven frames plus hand sequences,
// checked through a queue of expected frame results.
module tb_hex_scan_decoder;

    localparam int ND = 6;

    logic          clock = 1'b0;
    logic          resetn = 1'b1;
    logic          seg_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic [2:0]    digit_sel = 3'd0;
    logic [6:0]    seg_in = 7'h7F;
    logic [23:0]   value_out;
    logic          frame_valid;
    logic          frame_error;
    logic [1:0]    err_code;
    logic [2:0]    bad_digit;
    logic          busy;

    always #5 clock = ~clock;

    hex_scan_decoder #(
        .NUM_DIGITS(ND),
        .TIMEOUT(255)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .seg_valid(seg_valid),
        .frame_start(frame_start),
        .digit_sel(digit_sel),
        .seg_in(seg_in),
        .value_out(value_out),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .err_code(err_code),
        .bad_digit(bad_digit),
        .busy(busy)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        bit         ok;
    } vec_t;

    typedef struct {
        bit          is_err;
        logic [23:0] val;
        logic [1:0]  code;
        logic [2:0]  bad;
    } exp_t;

    vec_t tbl[20];
    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic void model(input logic [6:0] s, output bit ok,
                                  output logic [3:0] n);
        ok = 1'b0;
        n  = 4'h0;
        for (int j = 0; j < 16; j++) begin
            if (tbl[j].seg == s) begin
                ok = 1'b1;
                n  = tbl[j].nib;
            end
        end
    endfunction

    function automatic logic [5:0][6:0] pack6(
        input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
        input logic [6:0] d, input logic [6:0] e, input logic [6:0] f);
        return {f, e, d, c, b, a};
    endfunction

    // Scoreboard: every pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (resetn && (frame_valid || frame_error)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got fv=%0b fe=%0b want none",
                         frame_valid, frame_error);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_err) begin
                    chk("err_pulse", {30'd0, frame_valid, frame_error}, 32'd1);
                    chk("err_code", {30'd0, err_code}, {30'd0, mon_e.code});
                    chk("bad_digit", {29'd0, bad_digit}, {29'd0, mon_e.bad});
                end else begin
                    chk("ok_pulse", {30'd0, frame_valid, frame_error}, 32'd2);
                    chk("value_out", {8'd0, value_out}, {8'd0, mon_e.val});
                end
            end
        end
    end

    task automatic beat(input logic fs, input logic [2:0] sel,
                        input logic [6:0] seg);
        @(posedge clock);
        #1;
        seg_valid   = 1'b1;
        frame_start = fs;
        digit_sel   = sel;
        seg_in      = seg;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            seg_valid   = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending after %0d cycles want 0",
                     sb.size(), max);
            sb.delete();
        end
        idle(1);
    endtask

    task automatic send_frame(input logic [5:0][6:0] segs, input int gap);
        logic [23:0] v;
        bit          ok;
        logic [3:0]  n;
        v = '0;
        for (int i = 0; i < ND; i++) begin
            model(segs[i], ok, n);
            if (!ok) begin
                sb.push_back('{is_err: 1'b1, val: 24'h0,
                               code: 2'd1, bad: 3'(i)});
                beat(i == 0, 3'(i), segs[i]);
                idle(1);
                return;
            end
            v[4*i +: 4] = n;
            if (i == ND - 1) begin
                sb.push_back('{is_err: 1'b0, val: v, code: 2'd0, bad: 3'd0});
            end
            beat(i == 0, 3'(i), segs[i]);
            if (gap > 0 && i < ND - 1) begin
                idle(gap);
            end
        end
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0][6:0] segs;
        tbl[0]  = '{7'h40, 4'h0, 1'b1};
        tbl[1]  = '{7'h79, 4'h1, 1'b1};
        tbl[2]  = '{7'h24, 4'h2, 1'b1};
        tbl[3]  = '{7'h30, 4'h3, 1'b1};
        tbl[4]  = '{7'h19, 4'h4, 1'b1};
        tbl[5]  = '{7'h12, 4'h5, 1'b1};
        tbl[6]  = '{7'h02, 4'h6, 1'b1};
        tbl[7]  = '{7'h78, 4'h7, 1'b1};
        tbl[8]  = '{7'h00, 4'h8, 1'b1};
        tbl[9]  = '{7'h10, 4'h9, 1'b1};
        tbl[10] = '{7'h08, 4'hA, 1'b1};
        tbl[11] = '{7'h03, 4'hB, 1'b1};
        tbl[12] = '{7'h46, 4'hC, 1'b1};
        tbl[13] = '{7'h21, 4'hD, 1'b1};
        tbl[14] = '{7'h06, 4'hE, 1'b1};
        tbl[15] = '{7'h0E, 4'hF, 1'b1};
        tbl[16] = '{7'h7F, 4'h0, 1'b0};
        tbl[17] = '{7'h41, 4'h0, 1'b0};
        tbl[18] = '{7'h7E, 4'h0, 1'b0};
        tbl[19] = '{7'h01, 4'h0, 1'b0};

        #2;
        resetn = 1'b0;
        #3;
        chk("rst_value", {8'd0, value_out}, 32'd0);
        chk("rst_fv", {31'd0, frame_valid}, 32'd0);
        chk("rst_fe", {31'd0, frame_error}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        chk("rst_bad", {29'd0, bad_digit}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        idle(2);

        // 1: back-to-back digits, exact latency and busy.
        sb.push_back('{is_err: 1'b0, val: 24'h543210, code: 2'd0, bad: 3'd0});
        beat(1'b1, 3'd0, 7'h40);
        beat(1'b0, 3'd1, 7'h79);
        beat(1'b0, 3'd2, 7'h24);
        @(negedge clock);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        beat(1'b0, 3'd3, 7'h30);
        beat(1'b0, 3'd4, 7'h19);
        beat(1'b0, 3'd5, 7'h12);
        @(negedge clock);
        chk("t1_early_fv", {31'd0, frame_valid}, 32'd0);
        idle(1);
        @(negedge clock);
        chk("t1_latency_fv", {31'd0, frame_valid}, 32'd1);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        drain(10);

        // 2: gaps of 3 idle cycles.
        send_frame(pack6(7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08), 3);
        drain(10);
        chk("t2_value", {8'd0, value_out}, 32'h00ABCDEF);

        // 3: bad pattern keeps the previous good frame.
        send_frame(pack6(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79), 0);
        drain(10);
        send_frame(pack6(7'h40, 7'h79, 7'h7F, 7'h30, 7'h19, 7'h12), 0);
        drain(10);
        chk("t3_hold", {8'd0, value_out}, 32'h00123456);

        // 4: out-of-order digit, then recovery.
        sb.push_back('{is_err: 1'b1, val: 24'h0, code: 2'd2, bad: 3'd2});
        beat(1'b1, 3'd0, 7'h40);
        beat(1'b0, 3'd2, 7'h24);
        idle(1);
        drain(10);
        send_frame(pack6(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02), 1);
        drain(10);
        chk("t4_recover", {8'd0, value_out}, 32'h00654321);

        // 5: 255 silent cycles time out, 254 do not.
        sb.push_back('{is_err: 1'b1, val: 24'h0, code: 2'd3, bad: 3'd1});
        beat(1'b1, 3'd0, 7'h40);
        idle(255);
        drain(10);
        sb.push_back('{is_err: 1'b0, val: 24'h777777, code: 2'd0, bad: 3'd0});
        beat(1'b1, 3'd0, 7'h78);
        idle(254);
        for (int i = 1; i < ND; i++) begin
            beat(1'b0, 3'(i), 7'h78);
        end
        idle(1);
        drain(10);

        // Mid-frame restart aborts silently.
        beat(1'b1, 3'd0, 7'h79);
        beat(1'b0, 3'd1, 7'h79);
        send_frame(pack6(7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19), 0);
        drain(10);

        // Table: every legal pattern in every position, illegal ones inserted.
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < ND; i++) begin
                segs[i] = tbl[(k + i) % 16].seg;
            end
            if (!tbl[k].ok) begin
                segs[k - 16] = tbl[k].seg;
            end
            send_frame(segs, k % 3);
            drain(10);
        end

        // 6: async reset mid-frame, then a fresh frame.
        beat(1'b1, 3'd0, 7'h40);
        beat(1'b0, 3'd1, 7'h40);
        beat(1'b0, 3'd2, 7'h40);
        beat(1'b0, 3'd3, 7'h40);
        idle(1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_value", {8'd0, value_out}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_code", {30'd0, err_code}, 32'd0);
        chk("t6_bad", {29'd0, bad_digit}, 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        idle(1);
        send_frame(pack6(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00), 0);
        drain(10);
        chk("t6_fresh", {8'd0, value_out}, 32'h00888888);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
